axi4_stream_mux_rr: RTL and testbench

Parametrised N-channel AXI4-Stream packet multiplexer. It merges up to CN acquisition/generator streams into the single PS stream-to-DMA port, arbitrating packet by packet in round-robin order. Each output packet is tagged with its source channel. Long packets can optionally be split at a programmable beat count so DMA transfers stay bounded.

---
 rtl/axi4_stream_mux_rr.sv | 151 +++++++++++++++
 tb/tb_axi4_stream_mux_rr.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_mux_rr.sv
// Round-robin AXI4-Stream packet mux with TDEST tagging and optional burst splitting.
// Optional per-channel packet counters: define AXI4_STREAM_MUX_STAT_EN.
module axi4_stream_mux_rr #(
    parameter int CN = 4,
    parameter int DW = 32,
    parameter int KW = DW / 8,
    parameter int LW = 16,
    parameter int TW = $clog2(CN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CN*DW-1:0] s_tdata,
    input  logic [CN*KW-1:0] s_tkeep,
    input  logic [CN-1:0]    s_tlast,
    input  logic [CN-1:0]    s_tvalid,
    output logic [CN-1:0]    s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic [KW-1:0]    m_tkeep,
    output logic             m_tlast,
    output logic [TW-1:0]    m_tdest,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic [CN-1:0]    cfg_en,
    input  logic [LW-1:0]    cfg_max_len,
    output logic [CN*32-1:0] stat_pkt
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0] grant_q;
    logic [TW-1:0] last_q;
    logic [TW-1:0] pick;
    logic          found;
    logic [LW-1:0] cnt_q;

    logic [DW-1:0] sel_data;
    logic [KW-1:0] sel_keep;
    logic          sel_last;
    logic          sel_valid;
    logic          out_ready;
    logic          acc;
    logic          forced;
    logic          ld_last;

    // Rotating search beginning one past the previous winner
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= CN; i++) begin
            idx = (int'(last_q) + i) % CN;
            if (!found && s_tvalid[idx] && cfg_en[idx]) begin
                found = 1'b1;
                pick  = TW'(idx);
            end
        end
    end

    assign sel_data  = s_tdata[int'(grant_q)*DW +: DW];
    assign sel_keep  = s_tkeep[int'(grant_q)*KW +: KW];
    assign sel_last  = s_tlast[grant_q];
    assign sel_valid = s_tvalid[grant_q];

    assign out_ready = !m_tvalid || m_tready;

    // >= also covers a limit lowered below the beats already sent
    assign forced  = (cfg_max_len != '0) &&
                     (cnt_q >= cfg_max_len - LW'(1));
    assign ld_last = sel_last || forced;

    always_comb begin
        state_d  = state_q;
        s_tready = '0;
        acc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_tready[grant_q] = out_ready;
                acc = sel_valid && out_ready;
                if (acc && ld_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= TW'(CN - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                grant_q <= pick;
                last_q  <= pick;
                cnt_q   <= '0;
            end else if (acc && cnt_q != '1) begin
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tdest  <= '0;
        end else if (acc) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tlast  <= ld_last;
            m_tdest  <= grant_q;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef AXI4_STREAM_MUX_STAT_EN
    for (genvar c = 0; c < CN; c++) begin : g_stat
        logic [31:0] pkt_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pkt_q <= '0;
            end else if (m_tvalid && m_tready && m_tlast &&
                         m_tdest == TW'(c)) begin
                pkt_q <= pkt_q + 32'd1;
            end
        end
        assign stat_pkt[c*32 +: 32] = pkt_q;
    end
`else
    assign stat_pkt = '0;
`endif

endmodule

// File: tb/tb_axi4_stream_mux_rr.sv
// Randomized bench for axi4_stream_mux_rr against a packet-level round-robin model.
// Stat counters are checked when AXI4_STREAM_MUX_STAT_EN is defined.
module tb_axi4_stream_mux_rr;

    localparam int CN  = 4;
    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int LW  = 16;
    localparam int TW  = 2;
    localparam int OBW = TW + 1 + KW + DW;

    logic             clk_i;
    logic             rst_i;
    logic [CN*DW-1:0] s_tdata;
    logic [CN*KW-1:0] s_tkeep;
    logic [CN-1:0]    s_tlast;
    logic [CN-1:0]    s_tvalid;
    logic [CN-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast;
    logic [TW-1:0]    m_tdest;
    logic             m_tvalid;
    logic             m_tready;
    logic [CN-1:0]    cfg_en;
    logic [LW-1:0]    cfg_max_len;
    logic [CN*32-1:0] stat_pkt;

    axi4_stream_mux_rr #(
        .CN(CN), .DW(DW), .KW(KW), .LW(LW), .TW(TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tdest    (m_tdest),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .cfg_en     (cfg_en),
        .cfg_max_len(cfg_max_len),
        .stat_pkt   (stat_pkt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t       src_q[CN][$];
    logic [63:0] exp_q[$];
    logic [CN-1:0] offered;
    logic [CN-1:0] sop;
    logic [63:0] prev_out;
    bit          stall_prev;
    int          cyc;
    int          first_v, first_mv, first_out, last_out, n_extra;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int c, input logic l,
                                         input logic [KW-1:0] k,
                                         input logic [DW-1:0] d);
        logic [63:0] r;
        r = '0;
        r[OBW-1:0] = {TW'(c), l, k, d};
        return r;
    endfunction

    function automatic logic [63:0] obs();
        return pack(int'(m_tdest), m_tlast, m_tkeep, m_tdata);
    endfunction

    task automatic drive(input bit rnd_ready, input bit gap_ok);
        m_tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int c = 0; c < CN; c++) begin
            if (src_q[c].size() > 0) begin
                if (!offered[c])
                    offered[c] = !(gap_ok && !sop[c] &&
                                   $urandom_range(0, 3) == 0);
                s_tvalid[c]         = offered[c];
                s_tdata[c*DW +: DW] = src_q[c][0].d;
                s_tkeep[c*KW +: KW] = src_q[c][0].k;
                s_tlast[c]          = src_q[c][0].l;
            end else begin
                s_tvalid[c] = 1'b0;
                s_tlast[c]  = 1'b0;
            end
        end
    endtask

    task automatic sample();
        beat_t b;
        if (stall_prev) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", obs(), prev_out);
        end
        if (m_tvalid && !m_tready)
            chk("bp_ready", 64'(s_tready), 64'd0);
        for (int c = 0; c < CN; c++) begin
            if (s_tvalid[c] && s_tready[c]) begin
                b = src_q[c].pop_front();
                sop[c]     = b.l;
                offered[c] = 1'b0;
            end
        end
        if (m_tvalid && first_mv < 0) first_mv = cyc;
        if (m_tvalid && m_tready) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() > 0) chk("beat", obs(), exp_q.pop_front());
            else n_extra++;
        end
        stall_prev = m_tvalid && !m_tready;
        prev_out   = obs();
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        s_tvalid   = '0;
        s_tlast    = '0;
        m_tready   = 1'b0;
        offered    = '0;
        sop        = '1;
        stall_prev = 1'b0;
        for (int c = 0; c < CN; c++) src_q[c].delete();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_out", obs(), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd0);
        chk("rst_stat", 64'(|stat_pkt), 64'd0);
        rst_i = 1'b0;
    endtask

    task automatic run_phase(input logic [CN-1:0] en, input int ml,
                             input int max_pkts, input bit rnd_ready,
                             input bit gap_req);
        beat_t b;
        beat_t mq[CN][$];
        int    exp_stat[CN];
        int    beats, chunks, lg, sel, n, np, len, tail;
        bit    lst, gap_ok;
        do_reset();
        cfg_en      = en;
        cfg_max_len = LW'(ml);
        gap_ok      = gap_req && (ml == 0);
        for (int c = 0; c < CN; c++) begin
            np = $urandom_range(max_pkts, en[c] ? 1 : 0);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 8);
                for (int j = 0; j < len; j++) begin
                    b.d = $urandom;
                    b.k = KW'($urandom);
                    b.l = (j == len - 1);
                    src_q[c].push_back(b);
                end
            end
            mq[c]       = src_q[c];
            exp_stat[c] = 0;
        end
        // Packet-level model: rotate over channels with data, emit one chunk each
        beats  = 0;
        chunks = 0;
        lg     = CN - 1;
        while (1) begin
            sel = -1;
            for (int i = 1; i <= CN; i++) begin
                n = (lg + i) % CN;
                if (sel < 0 && en[n] && mq[n].size() > 0) sel = n;
            end
            if (sel < 0) break;
            n = 0;
            do begin
                b = mq[sel].pop_front();
                n++;
                beats++;
                lst = b.l || (ml != 0 && n == ml);
                exp_q.push_back(pack(sel, lst, b.k, b.d));
            end while (!lst);
            chunks++;
            exp_stat[sel]++;
            lg = sel;
        end
        cyc       = 0;
        first_v   = -1;
        first_mv  = -1;
        first_out = -1;
        last_out  = -1;
        n_extra   = 0;
        tail      = 0;
        while (cyc < 3000 && tail < 6) begin
            drive(rnd_ready && exp_q.size() > 0, gap_ok);
            if (first_v < 0 && |s_tvalid) first_v = cyc;
            @(negedge clk_i);
            sample();
            if (exp_q.size() == 0) tail++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("extra", 64'(n_extra), 64'd0);
        chk("first_lat", 64'(first_mv - first_v), 64'd2);
        if (!rnd_ready && !gap_ok)
            chk("span", 64'(last_out - first_out + 1),
                64'(beats + chunks - 1));
`ifdef AXI4_STREAM_MUX_STAT_EN
        for (int c = 0; c < CN; c++)
            chk("stat", 64'(stat_pkt[c*32 +: 32]), 64'(exp_stat[c]));
`else
        chk("stat_off", 64'(|stat_pkt), 64'd0);
`endif
    endtask

    task automatic rst_mid_test();
        beat_t b;
        int    n_acc;
        do_reset();
        cfg_en      = 4'b0100;
        cfg_max_len = '0;
        for (int j = 0; j < 8; j++) begin
            b.d = 32'h100 + 32'(j);
            b.k = '1;
            b.l = (j == 7);
            src_q[2].push_back(b);
        end
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 2 && cyc < 50) begin
            drive(1'b0, 1'b0);
            @(negedge clk_i);
            if (s_tvalid[2] && s_tready[2]) begin
                b = src_q[2].pop_front();
                n_acc++;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("mid_accepts", 64'(n_acc), 64'd2);
        drive(1'b0, 1'b0);
        #2;
        chk("mid_busy", 64'(m_tvalid), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_out", obs(), 64'd0);
        chk("mid_rst_ready", 64'(s_tready), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int c = 0; c < CN; c++) begin
            src_q[c].delete();
            b.d = 32'h200 + 32'(c);
            b.k = '1;
            b.l = 1'b1;
            src_q[c].push_back(b);
        end
        offered = '0;
        sop     = '1;
        cfg_en  = '1;
        cyc     = 0;
        while (!m_tvalid && cyc < 10) begin
            drive(1'b0, 1'b0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        chk("post_rst_valid", 64'(m_tvalid), 64'd1);
        chk("post_rst_dest", 64'(m_tdest), 64'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        cfg_en      = '0;
        cfg_max_len = '0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = '0;
        s_tvalid    = '0;
        m_tready    = 1'b0;
        offered     = '0;
        sop         = '1;
        stall_prev  = 1'b0;
        prev_out    = '0;
        @(posedge clk_i);
        #1;
        run_phase(4'b0001, 0, 1, 1'b0, 1'b0);
        run_phase(4'b1111, 0, 4, 1'b0, 1'b0);
        run_phase(4'b1111, 3, 4, 1'b0, 1'b0);
        run_phase(4'b0111, 3, 3, 1'b1, 1'b0);
        run_phase(4'b1111, 1, 3, 1'b1, 1'b0);
        for (int r = 0; r < 12; r++)
            run_phase(CN'($urandom_range(1, 15)), $urandom_range(0, 4),
                      6, 1'b1, 1'b1);
        rst_mid_test();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
